// File: rtl/seq_shift_add_multiplier_pkg.sv
// ============================================================================
// seq_shift_add_multiplier_pkg : shared state encoding and sizing constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_shift_add_multiplier_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;
    localparam int SHR_W         = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_shift_add_multiplier_datapath.sv
// ============================================================================
// seq_shift_add_multiplier_datapath : operand/product registers, adder, shift
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_shift_add_multiplier_datapath
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]     sum;
    logic [SHR_W-1:0]   shr_in;
    logic [SHR_W-1:0]   shr_out;
    logic               shr_msb_unused;

    // Full 33-bit sum; its carry replaces the zero the shifter inserts at the MSB.
    assign sum    = {1'b0, product_q[2*WIDTH-1:WIDTH]}
                  + (product_q[0] ? {1'b0, mcand_q} : '0);
    assign shr_in = {sum[WIDTH-1:0], product_q[WIDTH-1:0]};

    seq_shift_add_multiplier_shr64 u_shr64 (
        .en   (1'b1),
        .din  (shr_in),
        .dout (shr_out)
    );

    assign shr_msb_unused = shr_out[SHR_W-1];

    always_comb begin
        mcand_d   = mcand_q;
        product_d = product_q;
        if (load) begin
            mcand_d   = multiplicand;
            product_d = {{WIDTH{1'b0}}, multiplier};
        end else if (step) begin
            product_d = {sum[WIDTH], shr_out[SHR_W-2:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q   <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_multiplier_shr64.sv
// ============================================================================
// seq_shift_add_multiplier_shr64 : 64-bit one-bit logical right shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_shift_add_multiplier_shr64
    import seq_shift_add_multiplier_pkg::*;
(
    input  logic             en,
    input  logic [SHR_W-1:0] din,
    output logic [SHR_W-1:0] dout
);

    assign dout = en ? {1'b0, din[SHR_W-1:1]} : din;

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
// ============================================================================
// seq_shift_add_multiplier : sequential unsigned WIDTH x WIDTH shift-add multiply
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;
    logic             step;

    // busy/done are computed for the state being entered so they stay registered.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                step    = 1'b1;
                busy_d  = 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    seq_shift_add_multiplier_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .step         (step),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
// ============================================================================
// tb_seq_shift_add_multiplier : randomized self-checking bench, arithmetic model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_shift_add_multiplier;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          n_vec;
    int          n_err;
    logic [63:0] last_exp;

    seq_shift_add_multiplier dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'b0, a};
        wb = {32'b0, b};
        return wa * wb;
    endfunction

    // One complete operation from IDLE; operands are scrambled right after capture.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int   lat;
        bit   seen;
        bit   busy_ok;
        last_exp = ref_mul(a, b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'd32);
        check("busy_through_calc", 64'(busy_ok), 64'd1);
        check("product", product, last_exp);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_back_idle", 64'(busy), 64'd0);
        check("product_hold", product, last_exp);
    endtask

    initial begin
        int          cyc;
        int          d_idx [$];
        logic [31:0] ra;
        logic [31:0] rb;

        n_vec        = 0;
        n_err        = 0;
        last_exp     = '0;
        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'hCAFE_F00D;

        #1;
        check("reset_product", product, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_product", product, 64'd0);

        run_op(32'd3, 32'd5);
        check("3x5_const", product, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_const", product, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h8000_0000, 32'd2);
        check("msb_const", product, 64'h0000_0001_0000_0000);
        run_op(32'd0, 32'h1234_5678);
        run_op(32'h1234_5678, 32'd0);

        // start held high, operands changing during the first operation
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        cyc = 0;
        while (d_idx.size() < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                multiplicand = 32'd3;
                multiplier   = 32'd4;
            end
            if (cyc == 20) begin
                multiplicand = 32'd11;
                multiplier   = 32'd13;
            end
            if (done) begin
                d_idx.push_back(cyc);
                check("held_start_product", product,
                      (d_idx.size() == 1) ? ref_mul(32'd7, 32'd9) : ref_mul(32'd11, 32'd13));
                if (d_idx.size() == 2) start = 1'b0;
            end
        end
        check("held_start_pulses", 64'(d_idx.size()), 64'd2);
        if (d_idx.size() == 2) begin
            check("held_start_first_at", 64'(d_idx[0]), 64'd33);
            check("held_start_gap", 64'(d_idx[1] - d_idx[0]), 64'd34);
        end
        @(negedge clk);
        check("held_start_idle", 64'(busy), 64'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_product", product, 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(32'd100, 32'd100);
        check("after_rst_const", product, 64'd10000);

        // idle hold with start low
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_hold_product", product, 64'd10000);
            check("idle_hold_busy", 64'(busy), 64'd0);
            check("idle_hold_done", 64'(done), 64'd0);
        end

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
